// File: rtl/icache_pkg.sv
// Shared types and default sizing for the instruction-cache line controller.
package icache_pkg;

    localparam int unsigned DEF_ADDR_W         = 16;
    localparam int unsigned DEF_DATA_W         = 16;
    localparam int unsigned DEF_LINES          = 128;
    localparam int unsigned DEF_WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RESP = 2'd2
    } state_e;

    // Bit width that never collapses to zero, for fields that may be empty.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: synchronous write, combinational read.
module icache_data_ram #(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AW     = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Refill word write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/icache_line_ctrl.sv
// Direct-mapped instruction cache controller with line refill from memory.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_line_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned LINES          = DEF_LINES,
    parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instruction,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef ICACHE_STATS_EN
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
`endif
    input  logic              flush
);

    localparam int unsigned OFF_W     = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W     = $clog2(LINES);
    localparam int unsigned TAG_SH    = OFF_W + IDX_W;
    localparam int unsigned TAG_W     = ADDR_W - TAG_SH;
    localparam int unsigned OFF_W_S   = clog2_min1(WORDS_PER_LINE);
    localparam int unsigned IDX_W_S   = clog2_min1(LINES);
    localparam int unsigned RAM_DEPTH = LINES * WORDS_PER_LINE;
    localparam int unsigned RAM_AW    = clog2_min1(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(LINES - 1);
    localparam logic [ADDR_W-1:0] RAM_MASK = ADDR_W'(RAM_DEPTH - 1);

    state_e               state_q, state_d;
    logic [OFF_W_S-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]     tag_mem [LINES];
    logic                 mem_req_d, instr_valid_d;
    logic [ADDR_W-1:0]    mem_addr_d;
    logic [DATA_W-1:0]    instruction_d;
    logic                 tag_we, ram_we;
    logic [DATA_W-1:0]    ram_rdata;
    logic [RAM_AW-1:0]    ram_raddr, ram_waddr;
`ifdef ICACHE_STATS_EN
    logic                 hit_acc, miss_acc;
`endif

    // Address field decode for the CPU request and the latched miss address
    logic [IDX_W_S-1:0] cpu_idx, req_idx;
    logic [OFF_W_S-1:0] req_off;
    logic [TAG_W-1:0]   cpu_tag, req_tag;
    logic [ADDR_W-1:0]  req_base;
    logic               cpu_hit, last_word;

    assign cpu_idx   = IDX_W_S'((cpu_addr >> OFF_W) & IDX_MASK);
    assign cpu_tag   = TAG_W'(cpu_addr >> TAG_SH);
    assign req_idx   = IDX_W_S'((req_addr_q >> OFF_W) & IDX_MASK);
    assign req_tag   = TAG_W'(req_addr_q >> TAG_SH);
    assign req_off   = OFF_W_S'(req_addr_q & OFF_MASK);
    assign req_base  = req_addr_q & ~OFF_MASK;
    assign cpu_hit   = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign last_word = (cnt_q == OFF_W_S'(WORDS_PER_LINE - 1));

    // Index and offset are the low address bits, so they form the RAM address directly
    assign ram_raddr = (state_q == IDLE) ? RAM_AW'(cpu_addr & RAM_MASK)
                                         : RAM_AW'(req_addr_q & RAM_MASK);
    assign ram_waddr = RAM_AW'((req_base | ADDR_W'(cnt_q)) & RAM_MASK);

    // Ready must drop in the same cycle a flush is presented, hence decoded rather than registered
    assign cpu_ready = (state_q == IDLE) && !flush && !flush_pend_q;

    icache_data_ram #(
        .DEPTH  (RAM_DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_data_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (mem_rdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_addr_d    = req_addr_q;
        flush_pend_d  = flush_pend_q;
        valid_d       = valid_q;
        mem_req_d     = 1'b0;
        mem_addr_d    = mem_addr;
        instr_valid_d = 1'b0;
        instruction_d = instruction;
        tag_we        = 1'b0;
        ram_we        = 1'b0;
`ifdef ICACHE_STATS_EN
        hit_acc       = 1'b0;
        miss_acc      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (flush || flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else if (cpu_req) begin
                    if (cpu_hit) begin
                        instr_valid_d = 1'b1;
                        instruction_d = ram_rdata;
`ifdef ICACHE_STATS_EN
                        hit_acc       = 1'b1;
`endif
                    end else begin
                        valid_d[cpu_idx] = 1'b0;
                        req_addr_d       = cpu_addr;
                        cnt_d            = '0;
                        mem_req_d        = 1'b1;
                        mem_addr_d       = cpu_addr & ~OFF_MASK;
                        state_d          = FILL;
`ifdef ICACHE_STATS_EN
                        miss_acc         = 1'b1;
`endif
                    end
                end
            end
            FILL: begin
                mem_req_d = 1'b1;
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ack) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (last_word) begin
                        valid_d[req_idx] = 1'b1;
                        tag_we           = 1'b1;
                        mem_req_d        = 1'b0;
                        instr_valid_d    = 1'b1;
                        instruction_d    = (req_off == cnt_q) ? mem_rdata : ram_rdata;
                        state_d          = RESP;
                    end else begin
                        mem_addr_d = req_base | ADDR_W'(cnt_d);
                    end
                end
            end
            RESP: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_addr_q   <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            instr_valid  <= 1'b0;
            instruction  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_addr_q   <= req_addr_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            mem_req      <= mem_req_d;
            mem_addr     <= mem_addr_d;
            instr_valid  <= instr_valid_d;
            instruction  <= instruction_d;
        end
    end

    // Tag store, written when a refill completes
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // Accepted hit/miss counters, free-running and wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_acc)  hit_count  <= hit_count + 32'd1;
            if (miss_acc) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_line_ctrl.sv
// Self-checking bench for icache_line_ctrl with a reference cache model.
// Statistics checks are compiled in when ICACHE_STATS_EN is defined.
module tb_icache_line_ctrl;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned LINES = 128;
    localparam int unsigned WPL   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_ready;
    logic          instr_valid;
    logic [DW-1:0] instruction;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          flush = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [31:0]   hit_count, miss_count;
`endif

    int checks = 0;
    int errors = 0;
    bit stray_ack = 1'b0;

    // Reference model: per-line valid flag and resident line number (addr / WPL)
    bit          m_valid [LINES];
    int unsigned m_line  [LINES];
    int unsigned m_hits = 0;
    int unsigned m_misses = 0;

    icache_line_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_ready   (cpu_ready),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
`ifdef ICACHE_STATS_EN
        .hit_count   (hit_count),
        .miss_count  (miss_count),
`endif
        .flush       (flush)
    );

    always #5 clk = ~clk;

    // Memory: returns its address as data, acking after two cycles of request
    initial begin
        int lat;
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            if (stray_ack) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hDEAD;
                stray_ack = 1'b0;
                lat       = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
                lat     = 0;
            end else if (mem_req) begin
                lat++;
                if (lat >= 2) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr;
                    lat       = 0;
                end
            end else begin
                lat = 0;
            end
        end
    end

    function automatic int unsigned idx_of(input int unsigned a);
        return (a / WPL) % LINES;
    endfunction

    function automatic bit model_hit(input int unsigned a);
        return m_valid[idx_of(a)] && (m_line[idx_of(a)] == a / WPL);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endfunction

    // One fetch: compares hit/miss behaviour, refill order, latency and data
    task automatic do_fetch(input logic [AW-1:0] a, input int flush_after, input string name);
        logic [AW-1:0] got [$];
        bit exp_hit, saw_req, flushed;
        int n, iv_n, ack_n, w;
        int unsigned base;
        exp_hit = model_hit(a);
        base    = (a / WPL) * WPL;
        saw_req = 1'b0;
        flushed = 1'b0;
        iv_n    = 0;
        ack_n   = 0;
        w       = 0;
        while (!cpu_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        if (cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: cpu_ready=%b required 1", name, cpu_ready);
            return;
        end
        cpu_addr = a;
        cpu_req  = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        for (n = 1; n <= 80; n++) begin
            @(negedge clk);
            flush = 1'b0;
            if (mem_req) saw_req = 1'b1;
            if (mem_req && mem_ack) begin
                got.push_back(mem_addr);
                ack_n = n;
                if (got.size() == flush_after) begin
                    flush   = 1'b1;
                    flushed = 1'b1;
                end
            end
            if (instr_valid) begin
                iv_n = n;
                break;
            end
        end
        flush = 1'b0;
        checks++;
        if (iv_n == 0) begin
            errors++;
            $display("FAIL %s instr_valid_timeout: got none required a pulse", name);
        end
        checks++;
        if (instruction !== a) begin
            errors++;
            $display("FAIL %s instruction: got %h required %h", name, instruction, a);
        end
        if (exp_hit) begin
            checks++;
            if (iv_n != 1 || saw_req) begin
                errors++;
                $display("FAIL %s hit_latency: cycles=%0d mem_req_seen=%b required 1 and 0", name, iv_n, saw_req);
            end
            m_hits++;
        end else begin
            checks++;
            if (got.size() != WPL) begin
                errors++;
                $display("FAIL %s refill_count: got %0d required %0d", name, got.size(), WPL);
            end else begin
                for (int i = 0; i < WPL; i++) begin
                    if (got[i] !== AW'(base + i)) begin
                        errors++;
                        $display("FAIL %s refill_addr[%0d]: got %h required %h", name, i, got[i], AW'(base + i));
                        break;
                    end
                end
            end
            checks++;
            if (iv_n != ack_n + 1) begin
                errors++;
                $display("FAIL %s miss_latency: instr_valid cycle %0d required %0d", name, iv_n, ack_n + 1);
            end
            m_valid[idx_of(a)] = 1'b1;
            m_line[idx_of(a)]  = a / WPL;
            m_misses++;
        end
        if (flushed) model_clear();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cpu_ready !== 1'b1 || instr_valid !== 1'b0 || mem_req !== 1'b0 ||
            mem_addr !== '0 || instruction !== '0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b iv=%b mreq=%b maddr=%h instr=%h required 1 0 0 0 0",
                     cpu_ready, instr_valid, mem_req, mem_addr, instruction);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cpu_ready !== 1'b1 || instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b iv=%b mreq=%b required 1 0 0", cpu_ready, instr_valid, mem_req);
        end
`ifdef ICACHE_STATS_EN
        checks++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: hits=%0d misses=%0d required 0 0", hit_count, miss_count);
        end
`endif
        model_clear();
    endtask

    task automatic test_directed();
        do_fetch(16'h0106, 0, "cold_miss");
        do_fetch(16'h0105, 0, "hit");
        do_fetch(16'h0304, 0, "conflict_fill");
        do_fetch(16'h0104, 0, "conflict_remiss");
    endtask

    task automatic test_flush_during_fill();
        do_fetch(16'h0206, 1, "flush_in_fill");
        do_fetch(16'h0206, 0, "after_flush_miss");
    endtask

    task automatic test_flush_idle();
        do_fetch(16'h0040, 0, "prep_line");
        flush    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 16'h0041;
        #1;
        checks++;
        if (cpu_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_ready: got %b required 0", cpu_ready);
        end
        @(posedge clk);
        #1;
        flush   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_noaccept: iv=%b mreq=%b required 0 0", instr_valid, mem_req);
        end
        model_clear();
        @(posedge clk);
        #1;
        do_fetch(16'h0041, 0, "flush_idle_remiss");
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] base;
        base = 16'h0040;
        for (int i = 0; i < 4; i++) begin
            cpu_req  = 1'b1;
            cpu_addr = base + AW'(i);
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (instr_valid !== 1'b1 || instruction !== base + AW'(i - 1)) begin
                    errors++;
                    $display("FAIL b2b[%0d]: iv=%b instr=%h required 1 %h", i - 1, instr_valid, instruction, base + AW'(i - 1));
                end
            end
            @(posedge clk);
            #1;
            m_hits++;
        end
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instruction !== base + AW'(3)) begin
            errors++;
            $display("FAIL b2b[3]: iv=%b instr=%h required 1 %h", instr_valid, instruction, base + AW'(3));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stray_ack();
        bit bad;
        bad = 1'b0;
        stray_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ready !== 1'b1 || instr_valid !== 1'b0 || mem_req !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stray_ack: state disturbed ready=%b iv=%b mreq=%b", cpu_ready, instr_valid, mem_req);
        end
        @(posedge clk);
        #1;
        do_fetch(16'h0042, 0, "stray_ack_hit");
    endtask

    task automatic test_reset_during_fill();
        int acks, n;
        acks = 0;
        cpu_addr = 16'h0106;
        cpu_req  = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        for (n = 0; n < 40 && acks < 2; n++) begin
            @(negedge clk);
            if (mem_req && mem_ack) acks++;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (acks != 2 || mem_req !== 1'b0 || cpu_ready !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_fill: acks=%0d mreq=%b ready=%b iv=%b required 2 0 1 0",
                     acks, mem_req, cpu_ready, instr_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        stray_ack = 1'b1;
        model_clear();
        m_hits   = 0;
        m_misses = 0;
        repeat (2) @(posedge clk);
        #1;
        do_fetch(16'h0106, 0, "post_reset_miss");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int fa;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
                model_clear();
            end
            a = AW'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
            fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, WPL)) : 0;
            do_fetch(a, fa, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush_during_fill();
        test_flush_idle();
        test_back_to_back();
        test_stray_ack();
        test_reset_during_fill();
        test_random();
`ifdef ICACHE_STATS_EN
        checks++;
        if (hit_count !== m_hits || miss_count !== m_misses) begin
            errors++;
            $display("FAIL stats: hits=%0d misses=%0d required %0d %0d", hit_count, miss_count, m_hits, m_misses);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_line_ctrl.md
ICACHE_LINE_CTRL -- requirements
Module: icache_line_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, CPU and memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-003 SHALL have parameter LINES, default 128, number of direct-mapped lines (power of two).
REQ-004 SHALL have parameter WORDS_PER_LINE, default 4, words per line (power of two, >=1).
REQ-005 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port cpu_req  in  1  fetch request, sampled only when cpu_ready=1.
REQ-008 SHALL have port cpu_addr  in  ADDR_W  fetch word address.
REQ-009 SHALL have port cpu_ready  out  1  cache can accept a request this cycle.
REQ-010 SHALL have port instr_valid  out  1  one-cycle pulse, instruction valid.
REQ-011 SHALL have port instruction  out  DATA_W  fetched word, held until next instr_valid.
REQ-012 SHALL have port flush  in  1  invalidate all lines.
REQ-013 SHALL have ports mem_req out 1, mem_addr out ADDR_W: refill read request, held until acked.
REQ-014 SHALL have ports mem_ack in 1, mem_rdata in DATA_W: refill word returned when mem_ack=1.

Function
REQ-015 Address split SHALL be offset=low log2(WORDS_PER_LINE) bits, index=next log2(LINES) bits, tag=remaining upper bits; per-line storage = valid bit, tag, WORDS_PER_LINE data words.
REQ-016 FSM states SHALL be IDLE, FILL, RESP; cpu_ready=1 only in IDLE.
REQ-017 IDLE with cpu_req and hit (valid and tag match): instruction loaded, instr_valid=1 next cycle, stay in IDLE (one accepted request per cycle, 1-cycle hit latency).
REQ-018 IDLE with cpu_req and miss: latch address, clear line valid, go to FILL with word counter=0.
REQ-019 FILL: mem_req=1, mem_addr={tag,index,counter}; on mem_ack write mem_rdata to the word, increment counter; mem_addr changes only after ack; mem_req may stay high back-to-back.
REQ-020 Fill order SHALL be ascending from the line base regardless of requested offset; no critical-word-first.
REQ-021 On ack of last word: set valid, write tag, go to RESP; RESP drives instr_valid=1 with requested word and returns to IDLE (miss latency = one cycle after final mem_ack).
REQ-022 mem_ack outside FILL SHALL be ignored.
REQ-023 flush in IDLE SHALL clear all valid bits in one cycle and take priority over a simultaneous cpu_req (request not accepted, cpu_ready=0 that cycle).
REQ-024 flush during FILL or RESP SHALL be latched and applied on the cycle after RESP; the in-flight fill completes and its response is delivered.
REQ-025 LINES=1 or WORDS_PER_LINE=1 SHALL work (zero-width index/offset fields handled).

Reset
REQ-026 reset low SHALL immediately force: state IDLE, all valid bits 0, cpu_ready=1, instr_valid=0, mem_req=0, mem_addr=0, instruction=0, pending flush 0, word counter 0.
REQ-027 Reset during FILL SHALL abandon the fill; late mem_ack after release ignored; data/tag arrays need not be reset.

Configuration
REQ-028 Macro ICACHE_STATS_EN: when defined, SHALL add outputs hit_count and miss_count (32 bits each), incrementing on each accepted hit/miss, wrapping at 2^32, cleared by reset, unaffected by flush; when undefined, ports and counters SHALL not exist and function is otherwise identical.

Structure
REQ-029 Package icache_pkg SHALL hold the FSM state enum (IDLE, FILL, RESP) and default parameter constants.
REQ-030 Data storage SHALL be sub-module icache_data_ram (synchronous write, combinational read, LINES*WORDS_PER_LINE x DATA_W); valid/tag arrays stay in the top.

Verification (defaults; memory returns mem_rdata=mem_addr after 2-cycle ack latency)
REQ-031 Reset low then released -> cpu_ready=1, instr_valid=0, mem_req=0, hit_count=miss_count=0.
REQ-032 Cold req 0x0106 -> mem_addr 0x0104,0x0105,0x0106,0x0107 in order; instr_valid one cycle after 4th ack with instruction=0x0106; miss_count=1.
REQ-033 Then req 0x0105 -> instr_valid next cycle, instruction=0x0105, no mem_req, hit_count=1.
REQ-034 Req 0x0304 (same index 0x41, different tag) -> refill 0x0304..0x0307; subsequent req 0x0104 misses again.
REQ-035 flush asserted during 2nd fill word of 0x0206 -> instruction=0x0206 delivered, then req 0x0206 misses.
REQ-036 reset low after 2nd ack of a fill -> mem_req=0 same cycle; after release req 0x0106 misses and refills all 4 words.
